wait_state_bus_slave: RTL and testbench
=======================================

WAIT_STATE_BUS_SLAVE -- requirements
Module: wait_state_bus_slave

Interface
REQ-001 SHALL take parameter BASE_ADDR, default 20'h00000: first address decoded by this slave.
REQ-002 SHALL take parameter NUM_UNITS, default 1024: number of byte locations (1..2^20).
REQ-003 SHALL take parameter WAIT_STATES, default 2: READY-low cycles inserted per access (0..15).
REQ-004 SHALL have port CLK  input  1  system clock; all state changes on rising edge.
REQ-005 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-006 SHALL have port CS  input  1  active-high chip select from the system decoder.
REQ-007 SHALL have port RD  input  1  active-low read strobe.
REQ-008 SHALL have port WR  input  1  active-low write strobe.
REQ-009 SHALL have port Address  input  20  latched bus address.
REQ-010 SHALL have port Data  inout  8  demultiplexed data bus; high-impedance when not driving.
REQ-011 SHALL have port READY  output  1  wait request to the CPU; low inserts wait states.

Function
REQ-012 SHALL hold a byte array mem[0..NUM_UNITS-1]; offset = Address - BASE_ADDR, 20-bit unsigned.
REQ-013 SHALL treat Address as in range iff Address >= BASE_ADDR and offset < NUM_UNITS.
REQ-014 SHALL implement states IDLE, WAIT, ACCESS, DONE.
REQ-015 SHALL, in IDLE, start a cycle when CS=1, in range, and exactly one of RD, WR is low; it SHALL latch offset and direction (read/write) at that edge.
REQ-016 SHALL ignore a request with both RD and WR low, or with the address out of range: stay in IDLE, READY=1, Data high-impedance.
REQ-017 SHALL go from IDLE to WAIT with wait counter = WAIT_STATES-1 when WAIT_STATES>0, else directly to ACCESS.
REQ-018 SHALL drive READY=0 combinationally for every cycle in WAIT. This gives exactly WAIT_STATES READY-low cycles, counted from the edge after the start edge.
REQ-019 SHALL, in WAIT, decrement the counter each cycle and enter ACCESS on the edge where the counter is 0.
REQ-020 SHALL drive READY=1 in IDLE, ACCESS and DONE.
REQ-021 SHALL, for a read in ACCESS or DONE, drive Data = mem[latched offset] while CS=1 and RD=0; otherwise Data is high-impedance.
REQ-022 SHALL, for a write, store Data into mem[latched offset] exactly once, on the edge leaving ACCESS.
REQ-023 SHALL go from ACCESS to DONE unconditionally after one cycle.
REQ-024 SHALL leave DONE for IDLE when the latched strobe is high or CS=0. The next cycle then requires a fresh strobe assertion observed in IDLE.
REQ-025 SHALL abort when the strobe deasserts or CS drops during WAIT: go to IDLE, no memory write, READY=1 from the next cycle.
REQ-026 SHALL never change the latched offset or direction between the start edge and the return to IDLE.
REQ-027 SHALL use a counter 4 bits wide with no wrap: it never decrements below 0.

Reset
REQ-028 SHALL, when RESET=1 at a rising edge, enter IDLE and clear the wait counter and latched direction.
REQ-029 SHALL hold READY=1 and Data high-impedance during and immediately after reset, including reset mid-WAIT or mid-ACCESS.
REQ-030 SHALL give RESET priority over any simultaneous strobe; a write in progress at reset SHALL NOT modify mem.
REQ-031 SHALL leave mem contents unchanged by RESET.

Verification
REQ-032 Write then read, WAIT_STATES=2, BASE_ADDR=20'h80000: write 8'hA5 at 20'h80010, then read 20'h80010 -> READY low exactly 2 cycles in each access; read returns 8'hA5.
REQ-033 Zero wait states, WAIT_STATES=0: read at BASE_ADDR -> READY never low; Data valid the cycle after the start edge.
REQ-034 Bounds, NUM_UNITS=16, BASE_ADDR=20'h0FF00: access 20'h0FF0F is serviced; accesses 20'h0FF10 and 20'h0FEFF leave Data high-impedance and READY=1.
REQ-035 Abort: raise WR at the 1st WAIT cycle of a write of 8'h3C to offset 4 -> state IDLE, mem[4] keeps its prior value, READY=1 the next cycle.
REQ-036 Reset mid-access: assert RESET in WAIT during a write of 8'hFF -> READY=1 and Data high-impedance after the edge; subsequent read shows the old value.
REQ-037 Conflicting strobes: RD=0 and WR=0 together with CS=1 -> no response, no memory change.

Source files
------------

// File: rtl/wait_state_bus_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : wait_state_bus_slave
//  Description : Byte-wide memory slave on a demultiplexed RD/WR strobe bus,
//                inserting a fixed number of READY-low wait states per access.
//  Revision    : 1.0  initial release
// ============================================================================
module wait_state_bus_slave #(
   parameter logic [19:0] BASE_ADDR   = 20'h00000,
   parameter int unsigned NUM_UNITS   = 1024,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        CS,
   input  logic        RD,
   input  logic        WR,
   input  logic [19:0] Address,
   inout  wire  [7:0]  Data,
   output logic        READY
);

   localparam logic [1:0]  c_ST_IDLE   = 2'd0;
   localparam logic [1:0]  c_ST_WAIT   = 2'd1;
   localparam logic [1:0]  c_ST_ACCESS = 2'd2;
   localparam logic [1:0]  c_ST_DONE   = 2'd3;

   localparam int          c_IDX_W     = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
   localparam logic [20:0] c_NUM_UNITS = 21'(NUM_UNITS);
   localparam bit          c_HAS_WAIT  = (WAIT_STATES > 0);
   localparam logic [3:0]  c_WAIT_INIT = c_HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

   logic [1:0]         r_state;
   logic [3:0]         r_cnt;
   logic               r_dir;          // 1 = read, 0 = write
   logic [c_IDX_W-1:0] r_idx;
   logic [7:0]         r_mem [0:NUM_UNITS-1];

   logic [19:0]        w_offset;
   logic               w_in_range;
   logic               w_start;
   logic               w_release;
   logic               w_drive;
   logic [7:0]         w_rdata;

   assign w_offset   = Address - BASE_ADDR;
   assign w_in_range = (Address >= BASE_ADDR) && ({1'b0, w_offset} < c_NUM_UNITS);
   assign w_start    = (r_state == c_ST_IDLE) && CS && w_in_range && (RD ^ WR);

   // Only the strobe captured at the start edge ends or aborts the cycle.
   assign w_release  = (r_dir ? RD : WR) || !CS;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state <= c_ST_IDLE;
         r_cnt   <= 4'd0;
         r_dir   <= 1'b0;
         r_idx   <= '0;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (w_start) begin
                  r_idx <= w_offset[c_IDX_W-1:0];
                  r_dir <= !RD;
                  if (c_HAS_WAIT) begin
                     r_state <= c_ST_WAIT;
                     r_cnt   <= c_WAIT_INIT;
                  end else begin
                     r_state <= c_ST_ACCESS;
                  end
               end
            end
            c_ST_WAIT: begin
               if (w_release) begin
                  r_state <= c_ST_IDLE;
               end else if (r_cnt == 4'd0) begin
                  r_state <= c_ST_ACCESS;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            c_ST_ACCESS: begin
               r_state <= c_ST_DONE;
            end
            c_ST_DONE: begin
               if (w_release) begin
                  r_state <= c_ST_IDLE;
               end
            end
            default: begin
               r_state <= c_ST_IDLE;
            end
         endcase
      end
   end

   // Storage is deliberately not reset; a write is committed only when leaving ACCESS.
   always_ff @(posedge CLK) begin
      if (!RESET && (r_state == c_ST_ACCESS) && !r_dir) begin
         r_mem[r_idx] <= Data;
      end
   end

   assign w_rdata = r_mem[r_idx];
   assign w_drive = !RESET && r_dir && CS && !RD &&
                    ((r_state == c_ST_ACCESS) || (r_state == c_ST_DONE));

   assign Data  = w_drive ? w_rdata : 8'hzz;
   assign READY = RESET || (r_state != c_ST_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_wait_state_bus_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_wait_state_bus_slave
//  Description : Directed bench; three slaves with disjoint windows share one
//                pulled-up bus, so an undriven bus reads 8'hFF.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wait_state_bus_slave;

   logic        clk = 1'b0;
   logic        rst;
   logic        cs;
   logic        rd;
   logic        wr;
   logic [19:0] addr;
   logic [7:0]  tb_d;
   logic        tb_en;
   wire  [7:0]  bus;
   wire  [2:0]  w_rdy;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   assign bus = tb_en ? tb_d : 8'hzz;

   generate
      for (genvar g = 0; g < 8; g++) begin : g_pull
         pullup pu (bus[g]);
      end
   endgenerate

   wait_state_bus_slave #(.BASE_ADDR(20'h80000), .NUM_UNITS(1024), .WAIT_STATES(2)) u_a (
      .CLK(clk), .RESET(rst), .CS(cs), .RD(rd), .WR(wr),
      .Address(addr), .Data(bus), .READY(w_rdy[0]));

   wait_state_bus_slave #(.BASE_ADDR(20'h40000), .NUM_UNITS(1024), .WAIT_STATES(0)) u_b (
      .CLK(clk), .RESET(rst), .CS(cs), .RD(rd), .WR(wr),
      .Address(addr), .Data(bus), .READY(w_rdy[1]));

   wait_state_bus_slave #(.BASE_ADDR(20'h0FF00), .NUM_UNITS(16), .WAIT_STATES(2)) u_c (
      .CLK(clk), .RESET(rst), .CS(cs), .RD(rd), .WR(wr),
      .Address(addr), .Data(bus), .READY(w_rdy[2]));

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full bus cycle held for six edges, then released; counts READY-low cycles
   // and, for reads, checks the bus on the first ACCESS cycle.
   task automatic access(input string tag, input int sel, input logic [19:0] a,
                         input bit is_rd, input logic [7:0] wd,
                         input int exp_lows, input logic [7:0] exp_rd);
      int lows = 0;
      cs = 1'b1; addr = a; rd = !is_rd; wr = is_rd; tb_d = wd; tb_en = !is_rd;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (!w_rdy[sel]) lows++;
         if (is_rd && (i == exp_lows)) chk({tag, "_data"}, bus, exp_rd);
      end
      chk({tag, "_waits"}, 8'(lows), 8'(exp_lows));
      cs = 1'b0; rd = 1'b1; wr = 1'b1; tb_en = 1'b0;
      tick();
      chk({tag, "_ready_after"}, {7'd0, w_rdy[sel]}, 8'd1);
      chk({tag, "_idle_bus"}, bus, 8'hFF);
   endtask

   initial begin
      rst = 1'b1; cs = 1'b0; rd = 1'b1; wr = 1'b1; addr = '0; tb_d = '0; tb_en = 1'b0;
      tick();
      tick();
      chk("rst_ready", {5'd0, w_rdy}, 8'h07);
      chk("rst_bus", bus, 8'hFF);
      rst = 1'b0;
      tick();

      // Basic write/read with two wait states
      access("a_wr", 0, 20'h80010, 1'b0, 8'hA5, 2, 8'h00);
      access("a_rd", 0, 20'h80010, 1'b1, 8'h00, 2, 8'hA5);

      // Zero wait states: data valid the cycle after the start edge
      access("b_wr", 1, 20'h40000, 1'b0, 8'h6D, 0, 8'h00);
      access("b_rd", 1, 20'h40000, 1'b1, 8'h00, 0, 8'h6D);

      // Window boundaries of the 16-byte slave
      access("c_wr_top", 2, 20'h0FF0F, 1'b0, 8'h5A, 2, 8'h00);
      access("c_rd_top", 2, 20'h0FF0F, 1'b1, 8'h00, 2, 8'h5A);
      access("c_rd_above", 2, 20'h0FF10, 1'b1, 8'h00, 0, 8'hFF);
      access("c_rd_below", 2, 20'h0FEFF, 1'b1, 8'h00, 0, 8'hFF);

      // Abort by releasing WR in the first wait cycle
      access("ab_pre", 0, 20'h80004, 1'b0, 8'h11, 2, 8'h00);
      cs = 1'b1; addr = 20'h80004; rd = 1'b1; wr = 1'b0; tb_d = 8'h3C; tb_en = 1'b1;
      tick();
      chk("ab_wait", {7'd0, w_rdy[0]}, 8'd0);
      wr = 1'b1;
      tick();
      chk("ab_ready1", {7'd0, w_rdy[0]}, 8'd1);
      tick();
      chk("ab_ready2", {7'd0, w_rdy[0]}, 8'd1);
      cs = 1'b0; tb_en = 1'b0;
      tick();
      access("ab_rd", 0, 20'h80004, 1'b1, 8'h00, 2, 8'h11);

      // Reset while a write of 8'hFF waits
      access("rs_pre", 0, 20'h80008, 1'b0, 8'h22, 2, 8'h00);
      cs = 1'b1; addr = 20'h80008; rd = 1'b1; wr = 1'b0; tb_d = 8'hFF; tb_en = 1'b1;
      tick();
      chk("rs_wait", {7'd0, w_rdy[0]}, 8'd0);
      rst = 1'b1;
      #1;
      chk("rs_during", {7'd0, w_rdy[0]}, 8'd1);
      tick();
      chk("rs_after", {7'd0, w_rdy[0]}, 8'd1);
      rst = 1'b0; cs = 1'b0; wr = 1'b1; tb_en = 1'b0;
      #1;
      chk("rs_bus", bus, 8'hFF);
      tick();
      chk("rs_idle", {7'd0, w_rdy[0]}, 8'd1);
      access("rs_rd", 0, 20'h80008, 1'b1, 8'h00, 2, 8'h22);

      // Both strobes low: no response
      cs = 1'b1; addr = 20'h80010; rd = 1'b0; wr = 1'b0; tb_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("cf_ready", {7'd0, w_rdy[0]}, 8'd1);
         chk("cf_bus", bus, 8'hFF);
      end
      cs = 1'b0; rd = 1'b1; wr = 1'b1;
      tick();
      access("cf_rd", 0, 20'h80010, 1'b1, 8'h00, 2, 8'hA5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
